// File: rtl/sal_ddr_pkg.sv
// rtl/sal_ddr_pkg.sv - shared DDR2 command types, pin encodings and defaults
package sal_ddr_pkg;

    // Bank command codes as presented on req_cmd_i.
    typedef enum logic [1:0] {
        CMD_PRE = 2'd0,
        CMD_ACT = 2'd1,
        CMD_RD  = 2'd2,
        CMD_WR  = 2'd3
    } cmd_t;

    // {ras_n, cas_n, we_n} per command; NOP is the deselect idle value.
    localparam logic [2:0] PIN_NOP = 3'b111;
    localparam logic [2:0] PIN_ACT = 3'b011;
    localparam logic [2:0] PIN_RD  = 3'b101;
    localparam logic [2:0] PIN_WR  = 3'b100;
    localparam logic [2:0] PIN_PRE = 3'b010;

    // Default width of timing-config inputs.
    localparam int TW_DEF = 5;

    // Activates tracked by the four-activate window.
    localparam int FAW_SLOTS = 4;

    function automatic logic [2:0] cmd_pins(input cmd_t c);
        logic [2:0] p;
        case (c)
            CMD_ACT: p = PIN_ACT;
            CMD_RD:  p = PIN_RD;
            CMD_WR:  p = PIN_WR;
            default: p = PIN_PRE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sal_rr_arbiter.sv
// rtl/sal_rr_arbiter.sv - N-way round-robin picker starting at a pointer
//
// Ports:
//   req_i   - request vector
//   ptr_i   - first index considered (highest priority this cycle)
//   gnt_o   - one-hot grant, zero when no request
//   idx_o   - index of the granted requester
//   valid_o - a grant was made
module sal_rr_arbiter #(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // Walk from the pointer, wrapping, and take the first requester.
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                idx_o      = PW'(idx);
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sal_cmd_sched.sv
// rtl/sal_cmd_sched.sv - shared DFI command bus scheduler with inter-bank timing
//
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   req_valid_i/cmd_i/addr_i   - per-bank pending command (flattened per bank)
//   gnt_o                      - one-hot grant, combinational, same cycle as acceptance
//   t_rrd/faw/ccd/wr2rd/rd2wr  - timing config in cycles (quasi-static)
//   dfi_*_o                    - registered DDR2 command pins, one cycle after grant
module sal_cmd_sched
    import sal_ddr_pkg::*;
#(
    parameter int BK_CNT = 8,
    parameter int BA_W   = 3,
    parameter int ADDR_W = 14,
    parameter int TW     = TW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BK_CNT-1:0]        req_valid_i,
    input  logic [2*BK_CNT-1:0]      req_cmd_i,
    input  logic [ADDR_W*BK_CNT-1:0] req_addr_i,
    output logic [BK_CNT-1:0]        gnt_o,
    input  logic [TW-1:0]            t_rrd_i,
    input  logic [TW-1:0]            t_faw_i,
    input  logic [TW-1:0]            t_ccd_i,
    input  logic [TW-1:0]            t_wr2rd_i,
    input  logic [TW-1:0]            t_rd2wr_i,
    output logic                     dfi_cs_n_o,
    output logic                     dfi_ras_n_o,
    output logic                     dfi_cas_n_o,
    output logic                     dfi_we_n_o,
    output logic [BA_W-1:0]          dfi_ba_o,
    output logic [ADDR_W-1:0]        dfi_addr_o
);

    // Loading T-1 puts the next constrained command exactly T cycles later.
    function automatic logic [TW-1:0] ld(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    function automatic logic [TW-1:0] dec(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - TW'(1);
    endfunction

    logic [TW-1:0]   rrd_q, rrd_d, ccd_q, ccd_d;
    logic [TW-1:0]   wr2rd_q, wr2rd_d, rd2wr_q, rd2wr_d;
    logic [TW-1:0]   faw_q [FAW_SLOTS];
    logic [TW-1:0]   faw_d [FAW_SLOTS];
    logic [BA_W-1:0] ptr_q, ptr_d;

    logic            cs_n_q, cs_n_d;
    logic [2:0]      rcw_q, rcw_d;
    logic [BA_W-1:0] ba_q, ba_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [BK_CNT-1:0] cas_req, act_req, pre_req, arb_req, arb_gnt;
    logic [BA_W-1:0]   arb_idx;
    logic              arb_valid, faw_avail, faw_loaded;
    cmd_t              gnt_cmd;
    logic [ADDR_W-1:0] gnt_addr;

    // Sort eligible requests into classes; only the highest non-empty class
    // reaches the arbiter so CAS beats ACT beats PRE.
    always_comb begin
        faw_avail = 1'b0;
        for (int k = 0; k < FAW_SLOTS; k++) begin
            if (faw_q[k] == '0) faw_avail = 1'b1;
        end
        cas_req = '0;
        act_req = '0;
        pre_req = '0;
        for (int i = 0; i < BK_CNT; i++) begin
            if (req_valid_i[i]) begin
                case (cmd_t'(req_cmd_i[2*i +: 2]))
                    CMD_RD:  cas_req[i] = (ccd_q == '0) && (wr2rd_q == '0);
                    CMD_WR:  cas_req[i] = (ccd_q == '0) && (rd2wr_q == '0);
                    CMD_ACT: act_req[i] = (rrd_q == '0) && faw_avail;
                    default: pre_req[i] = 1'b1;
                endcase
            end
        end
        if (rst)             arb_req = '0;
        else if (|cas_req)   arb_req = cas_req;
        else if (|act_req)   arb_req = act_req;
        else                 arb_req = pre_req;
    end

    sal_rr_arbiter #(
        .N  (BK_CNT),
        .PW (BA_W)
    ) u_arb (
        .req_i   (arb_req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign gnt_o = arb_gnt;

    always_comb begin
        gnt_cmd  = CMD_PRE;
        gnt_addr = '0;
        for (int i = 0; i < BK_CNT; i++) begin
            if (arb_gnt[i]) begin
                gnt_cmd  = cmd_t'(req_cmd_i[2*i +: 2]);
                gnt_addr = req_addr_i[ADDR_W*i +: ADDR_W];
            end
        end
    end

    // Counter, pointer and pin next-state.
    always_comb begin
        rrd_d   = dec(rrd_q);
        ccd_d   = dec(ccd_q);
        wr2rd_d = dec(wr2rd_q);
        rd2wr_d = dec(rd2wr_q);
        for (int k = 0; k < FAW_SLOTS; k++) faw_d[k] = dec(faw_q[k]);
        faw_loaded = 1'b0;
        ptr_d      = ptr_q;

        if (arb_valid) begin
            ptr_d = (arb_idx == BA_W'(BK_CNT - 1)) ? '0 : arb_idx + BA_W'(1);
            case (gnt_cmd)
                CMD_ACT: begin
                    rrd_d = ld(t_rrd_i);
                    for (int k = 0; k < FAW_SLOTS; k++) begin
                        if (!faw_loaded && faw_q[k] == '0) begin
                            faw_d[k]   = ld(t_faw_i);
                            faw_loaded = 1'b1;
                        end
                    end
                end
                CMD_RD: begin
                    ccd_d   = ld(t_ccd_i);
                    rd2wr_d = ld(t_rd2wr_i);
                end
                CMD_WR: begin
                    ccd_d   = ld(t_ccd_i);
                    wr2rd_d = ld(t_wr2rd_i);
                end
                default: ;
            endcase
        end

        cs_n_d = !arb_valid;
        rcw_d  = arb_valid ? cmd_pins(gnt_cmd) : PIN_NOP;
        ba_d   = arb_valid ? arb_idx : '0;
        // PRE drives addr[10]=0 (single-bank precharge) with the rest zero.
        addr_d = (arb_valid && gnt_cmd != CMD_PRE) ? gnt_addr : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rrd_q   <= '0;
            ccd_q   <= '0;
            wr2rd_q <= '0;
            rd2wr_q <= '0;
            for (int k = 0; k < FAW_SLOTS; k++) faw_q[k] <= '0;
            ptr_q   <= '0;
            cs_n_q  <= 1'b1;
            rcw_q   <= PIN_NOP;
            ba_q    <= '0;
            addr_q  <= '0;
        end else begin
            rrd_q   <= rrd_d;
            ccd_q   <= ccd_d;
            wr2rd_q <= wr2rd_d;
            rd2wr_q <= rd2wr_d;
            for (int k = 0; k < FAW_SLOTS; k++) faw_q[k] <= faw_d[k];
            ptr_q   <= ptr_d;
            cs_n_q  <= cs_n_d;
            rcw_q   <= rcw_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
        end
    end

    assign dfi_cs_n_o  = cs_n_q;
    assign dfi_ras_n_o = rcw_q[2];
    assign dfi_cas_n_o = rcw_q[1];
    assign dfi_we_n_o  = rcw_q[0];
    assign dfi_ba_o    = ba_q;
    assign dfi_addr_o  = addr_q;

endmodule

// File: tb/tb_sal_cmd_sched.sv
// tb/tb_sal_cmd_sched.sv - directed self-checking bench for sal_cmd_sched
module tb_sal_cmd_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   req_valid = '0;
    logic [15:0]  req_cmd = '0;
    logic [111:0] req_addr = '0;
    logic [7:0]   gnt;
    logic [4:0]   t_rrd = 5'd2, t_faw = 5'd10, t_ccd = 5'd4, t_wr2rd = 5'd9, t_rd2wr = 5'd6;
    logic         cs_n, ras_n, cas_n, we_n;
    logic [2:0]   ba;
    logic [13:0]  addr;

    int errors = 0;
    int checks = 0;
    bit auto_drop = 1'b1;

    always #5 clk = ~clk;

    sal_cmd_sched dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_cmd_i   (req_cmd),
        .req_addr_i  (req_addr),
        .gnt_o       (gnt),
        .t_rrd_i     (t_rrd),
        .t_faw_i     (t_faw),
        .t_ccd_i     (t_ccd),
        .t_wr2rd_i   (t_wr2rd),
        .t_rd2wr_i   (t_rd2wr),
        .dfi_cs_n_o  (cs_n),
        .dfi_ras_n_o (ras_n),
        .dfi_cas_n_o (cas_n),
        .dfi_we_n_o  (we_n),
        .dfi_ba_o    (ba),
        .dfi_addr_o  (addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pin bundle {cs_n, ras_n, cas_n, we_n, ba, addr}.
    function automatic logic [31:0] pk(input logic cs, input logic [2:0] rcw,
                                       input logic [2:0] b, input logic [13:0] a);
        return {11'd0, cs, rcw, b, a};
    endfunction

    function automatic logic [31:0] pins();
        return {11'd0, cs_n, ras_n, cas_n, we_n, ba, addr};
    endfunction

    // Advance one clock; granted banks drop their request after the edge.
    task automatic tick();
        logic [7:0] gl;
        gl = gnt;
        @(posedge clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~gl;
        #1;
    endtask

    task automatic set_req(input int b, input logic [1:0] c, input logic [13:0] a);
        req_valid[b]       = 1'b1;
        req_cmd[2*b +: 2]  = c;
        req_addr[14*b +: 14] = a;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_g [11];
        exp_g = '{8'h01, 0, 8'h02, 0, 8'h04, 0, 8'h08, 0, 0, 0, 8'h10};

        // Reset state
        rst = 1'b1;
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        tick();
        tick();
        chk("rst_pins", pins(), pk(1'b1, 3'b111, 3'd0, 14'h0));
        rst = 1'b0;
        #1;

        // Single ACT from bank 3
        set_req(3, 2'd1, 14'h1A5);
        #1;
        chk("act1_gnt", 32'(gnt), 32'h08);
        tick();
        chk("act1_gnt_off", 32'(gnt), 32'h0);
        chk("act1_pins", pins(), pk(1'b0, 3'b011, 3'd3, 14'h1A5));
        tick();
        chk("act1_desel", pins(), pk(1'b1, 3'b111, 3'd0, 14'h0));
        idle(12);

        // Five ACTs: tRRD=2 spacing, fifth held by tFAW=10
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int b = 0; b < 5; b++) set_req(b, 2'd1, 14'(14'h100 + b));
        #1;
        for (int c = 0; c < 11; c++) begin
            chk($sformatf("faw_c%0d", c), 32'(gnt), 32'(exp_g[c]));
            tick();
        end
        chk("faw_last_pins", pins(), pk(1'b0, 3'b011, 3'd4, 14'h104));
        idle(12);

        // CAS priority over ACT, then tCCD on a second RD
        set_req(1, 2'd2, 14'h021);
        set_req(2, 2'd1, 14'h222);
        #1;
        chk("cas_first", 32'(gnt), 32'h02);
        tick();
        set_req(5, 2'd2, 14'h055);
        #1;
        chk("act_second", 32'(gnt), 32'h04);
        chk("rd_pins", pins(), pk(1'b0, 3'b101, 3'd1, 14'h021));
        tick();
        chk("ccd_c2", 32'(gnt), 32'h0);
        tick();
        chk("ccd_c3", 32'(gnt), 32'h0);
        tick();
        chk("ccd_c4", 32'(gnt), 32'h20);
        idle(12);

        // WR -> RD turnaround (9), then RD -> WR turnaround (6)
        set_req(0, 2'd3, 14'h055);
        #1;
        chk("wr_gnt", 32'(gnt), 32'h01);
        tick();
        set_req(1, 2'd2, 14'h077);
        #1;
        chk("wr_pins", pins(), pk(1'b0, 3'b100, 3'd0, 14'h055));
        n = 1;
        while (gnt == 8'h0 && n < 30) begin
            tick();
            n++;
        end
        chk("wr2rd_gap", 32'(n), 32'd9);
        chk("wr2rd_gnt", 32'(gnt), 32'h02);
        tick();
        set_req(0, 2'd3, 14'h099);
        #1;
        n = 1;
        while (gnt == 8'h0 && n < 30) begin
            tick();
            n++;
        end
        chk("rd2wr_gap", 32'(n), 32'd6);
        chk("rd2wr_gnt", 32'(gnt), 32'h01);
        tick();
        idle(12);

        // Eight PREs held continuously: rotation starts after last grant (bank 0)
        auto_drop = 1'b0;
        for (int b = 0; b < 8; b++) set_req(b, 2'd0, 14'h3FFF);
        #1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("pre_gnt%0d", k), 32'(gnt), 32'(8'h01 << ((1 + k) % 8)));
            if (k > 0)
                chk($sformatf("pre_pins%0d", k), pins(), pk(1'b0, 3'b010, 3'(k % 8), 14'h0));
            tick();
        end
        req_valid = '0;
        auto_drop = 1'b1;
        tick();

        // Reset mid-operation with counters loaded and requests pending
        set_req(6, 2'd3, 14'h066);
        #1;
        chk("pre_rst_wr", 32'(gnt), 32'h40);
        tick();
        set_req(2, 2'd1, 14'h122);
        #1;
        chk("pre_rst_act", 32'(gnt), 32'h04);
        tick();
        rst = 1'b1;
        set_req(0, 2'd2, 14'h0A0);
        set_req(4, 2'd2, 14'h0A4);
        set_req(5, 2'd1, 14'h0A5);
        #1;
        chk("rst_cycle_gnt", 32'(gnt), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_pins", pins(), pk(1'b1, 3'b111, 3'd0, 14'h0));
        chk("post_rst_gnt", 32'(gnt), 32'h01);
        tick();
        chk("post_rst_rd_pins", pins(), pk(1'b0, 3'b101, 3'd0, 14'h0A0));
        chk("post_rst_act_gnt", 32'(gnt), 32'h20);
        tick();
        chk("post_rst_act_pins", pins(), pk(1'b0, 3'b011, 3'd5, 14'h0A5));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sal_cmd_sched.md
Name: sal_cmd_sched

Overview:
Command scheduler that shares the single DFI command bus among the per-bank controllers of the DDR2 controller. Each cycle it picks at most one pending bank command (PRE/ACT/RD/WR) and enforces inter-bank timing: tRRD, tFAW, tCCD, write-to-read and read-to-write. It then drives the registered DDR2 command pins. It sits between the BK_CTRL array and the DFI control interface, replacing the direct BK_CTRL→DFI connection.

Parameters:
BK_CNT, 8, number of banks/requesters
BA_W, 3, bank-address width (log2 BK_CNT)
ADDR_W, 14, DRAM address width
TW, 5, width of every timing-config input

Ports:
clk  in  1  controller clock
rst  in  1  synchronous reset, active-high
req_valid_i  in  BK_CNT  bank i has a command pending
req_cmd_i  in  2*BK_CNT  per-bank command: 0=PRE, 1=ACT, 2=RD, 3=WR
req_addr_i  in  ADDR_W*BK_CNT  per-bank row (ACT) or column (RD/WR); ignored for PRE
gnt_o  out  BK_CNT  one-hot grant, same cycle as acceptance
t_rrd_i  in  TW  ACT→ACT, any bank
t_faw_i  in  TW  four-activate window
t_ccd_i  in  TW  CAS→CAS
t_wr2rd_i  in  TW  WR→RD (CWL+BL/2+tWTR, precomputed)
t_rd2wr_i  in  TW  RD→WR bus turnaround
dfi_cs_n_o  out  1  chip select
dfi_ras_n_o  out  1
dfi_cas_n_o  out  1
dfi_we_n_o  out  1
dfi_ba_o  out  BA_W
dfi_addr_o  out  ADDR_W

Behaviour:
- Reset: all outputs deasserted. gnt_o=0, cs_n/ras_n/cas_n/we_n=1, ba=0, addr=0. All timing counters=0. RR pointer=0. Reset mid-operation drops any in-flight decision; no command is issued in the reset cycle or the cycle after it.
- Handshake: a bank holds valid/cmd/addr stable until it sees gnt_o[i]=1. gnt_o is combinational from registered state plus inputs. A bank deasserts or changes its request the cycle after the grant.
- Latency: command granted in cycle N appears on the dfi_* pins in cycle N+1 for exactly one cycle. Cycles with no grant drive deselect (cs_n=1, others 1).
- Pin encoding (cs_n=0 when issuing):
  - ACT: ras=0, cas=1, we=1
  - RD: ras=1, cas=0, we=1
  - WR: ras=1, cas=0, we=0
  - PRE: ras=0, cas=1, we=0, addr[10]=0, rest 0
  - ba = granted bank index.
- Eligibility. A request is eligible when every rule for its type holds:
  - ACT: rrd_cnt==0 and at least one faw_cnt[k]==0.
  - RD: ccd_cnt==0 and wr2rd_cnt==0.
  - WR: ccd_cnt==0 and rd2wr_cnt==0.
  - PRE: always eligible.
- Counters: down-counters, saturate at 0. On issue, load T-1; a value of 0 or 1 means no constraint. This places the next constrained command exactly T cycles after the first.
  - ACT loads rrd_cnt and the lowest-index faw_cnt that is 0.
  - RD loads ccd_cnt and rd2wr_cnt.
  - WR loads ccd_cnt and wr2rd_cnt.
  - Same-cycle load overrides decrement.
- Timing inputs are quasi-static. A change affects only subsequent loads.
- Arbitration: classes in strict priority CAS (RD/WR) > ACT > PRE. Within the highest non-empty eligible class, grant the first eligible bank at or after the RR pointer, wrapping at BK_CNT-1→0.
- Pointer update: after any grant, the pointer = granted index+1, mod BK_CNT. With no grant, the pointer holds.
- At most one grant per cycle. Ineligible requests wait without starvation of eligible ones.

Decomposition:
- Shared package sal_ddr_pkg holds:
  - cmd_t enum (PRE/ACT/RD/WR)
  - DDR2 pin-encoding constants
  - TW default
- Sub-module sal_rr_arbiter: parameterised N-way round-robin picker (req vector, pointer → one-hot grant). Instantiated once per class, or once on the class-masked vector.
- Timing counters stay in the top.

Test Plan:
- Single ACT from bank 3, addr 0x1A5, t_rrd=2 → gnt_o=0x08 at cycle N; at N+1 cs=0, ras=0, cas=1, we=1, ba=3, addr=0x1A5; deselect at N+2.
- Banks 0–4 request ACT together, t_rrd=2, t_faw=10 → ACT grants at cycles 0, 2, 4, 6; bank 4 held until cycle 10; grant order 0, 1, 2, 3, 4.
- Bank 1 RD and bank 2 ACT pending together → RD granted first, ACT next cycle. A following RD to bank 5 with t_ccd=4 is granted no earlier than 4 cycles after the first RD.
- WR on bank 0 then RD on bank 1, t_wr2rd=9 → RD granted exactly 9 cycles after WR. RD then WR with t_rd2wr=6 → WR at +6.
- All 8 banks hold PRE continuously → grants rotate 0..7, then 0 again, each bank once per 8 cycles; pins show PRE with addr[10]=0.
- rst asserted for 1 cycle while 3 requests are pending and counters are non-zero → next cycle all outputs at reset values; after release the pointer is 0 and bank 0 is granted first with no stale timing block.
